// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage RV immediate generator (S1 holds the instruction, S2 the decoded result)
// with valid/ready backpressure, flush and a sideband tag. Macro IMMGEN_ZIMM_EN decodes CSR*I zimm.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FmtU       = 3'd0,
        FmtJ       = 3'd1,
        FmtI       = 3'd2,
        FmtUimm    = 3'd3,
        FmtS       = 3'd4,
        FmtB       = 3'd5,
        FmtNone    = 3'd6,
        FmtIllegal = 3'd7
    } fmt_e;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpOp32    = 7'b0111011;
    localparam logic [6:0] OpFence   = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    localparam bit Rv64 = (XLEN == 64);

    // Replicates bit 31 of a 32-bit pre-assembled immediate up to XLEN-1.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic             r_s1_valid;
    logic [31:0]      r_s1_inst;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_imm;
    logic [2:0]       r_s2_fmt;
    logic             r_s2_illegal;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [XLEN-1:0]  w_imm;
    fmt_e             w_fmt;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = (!r_s1_valid || w_s2_adv) && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_opcode = r_s1_inst[6:0];
    assign w_funct3 = r_s1_inst[14:12];

    always_comb begin
        w_fmt = FmtIllegal;
        w_imm = '0;
        if (r_s1_inst[1:0] == 2'b11) begin
            case (w_opcode)
                OpLui, OpAuipc: begin
                    w_fmt = FmtU;
                    w_imm = sext32({r_s1_inst[31:12], 12'b0});
                end
                OpJal: begin
                    w_fmt = FmtJ;
                    w_imm = sext32({{11{r_s1_inst[31]}}, r_s1_inst[31], r_s1_inst[19:12],
                                    r_s1_inst[20], r_s1_inst[30:21], 1'b0});
                end
                OpJalr, OpLoad: begin
                    w_fmt = FmtI;
                    w_imm = sext32({{20{r_s1_inst[31]}}, r_s1_inst[31:20]});
                end
                OpStore: begin
                    w_fmt = FmtS;
                    w_imm = sext32({{20{r_s1_inst[31]}}, r_s1_inst[31:25], r_s1_inst[11:7]});
                end
                OpBranch: begin
                    w_fmt = FmtB;
                    w_imm = sext32({{19{r_s1_inst[31]}}, r_s1_inst[31], r_s1_inst[7],
                                    r_s1_inst[30:25], r_s1_inst[11:8], 1'b0});
                end
                OpOpImm: begin
                    // funct3 001/101 are the shifts: shamt is a zero-extended field.
                    if (w_funct3[1:0] == 2'b01) begin
                        if (Rv64) begin
                            w_fmt = FmtUimm;
                            w_imm = XLEN'(r_s1_inst[25:20]);
                        end else if (!r_s1_inst[25]) begin
                            w_fmt = FmtUimm;
                            w_imm = XLEN'(r_s1_inst[24:20]);
                        end
                    end else begin
                        w_fmt = FmtI;
                        w_imm = sext32({{20{r_s1_inst[31]}}, r_s1_inst[31:20]});
                    end
                end
                OpOpImm32: begin
                    if (Rv64) begin
                        if (w_funct3[1:0] == 2'b01) begin
                            if (!r_s1_inst[25]) begin
                                w_fmt = FmtUimm;
                                w_imm = XLEN'(r_s1_inst[24:20]);
                            end
                        end else begin
                            w_fmt = FmtI;
                            w_imm = sext32({{20{r_s1_inst[31]}}, r_s1_inst[31:20]});
                        end
                    end
                end
                OpOp, OpFence: w_fmt = FmtNone;
                OpOp32: begin
                    if (Rv64) begin
                        w_fmt = FmtNone;
                    end
                end
                OpSystem: begin
`ifdef IMMGEN_ZIMM_EN
                    if (w_funct3[2]) begin
                        w_fmt = FmtUimm;
                        w_imm = XLEN'(r_s1_inst[19:15]);
                    end else begin
                        w_fmt = FmtNone;
                    end
`else
                    w_fmt = FmtNone;
`endif
                end
                default: w_fmt = FmtIllegal;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_inst    <= '0;
            r_s1_tag     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_imm     <= '0;
            r_s2_fmt     <= FmtNone;
            r_s2_illegal <= 1'b0;
            r_s2_tag     <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_inst  <= in_inst;
                r_s1_tag   <= in_tag;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            // S2 data only changes on a transfer, so a stalled result stays bit-stable.
            if (w_s1_adv) begin
                r_s2_valid   <= 1'b1;
                r_s2_imm     <= w_imm;
                r_s2_fmt     <= w_fmt;
                r_s2_illegal <= (w_fmt == FmtIllegal);
                r_s2_tag     <= r_s1_tag;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_imm     = r_s2_imm;
    assign out_fmt     = r_s2_fmt;
    assign out_illegal = r_s2_illegal;
    assign out_tag     = r_s2_tag;

    a_illegal_fmt: assert property (@(posedge clk) out_illegal == (out_fmt == FmtIllegal));

    a_stall_stable: assert property (@(posedge clk)
        (!rst && r_s2_valid && !out_ready) |=>
            ($stable(r_s2_imm) && $stable(r_s2_fmt) && $stable(r_s2_tag)));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; directed vector table
// plus hand-written reset, stall/drain and flush sequences.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [31:0] tag32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [31:0] tag64;

    int n_pass;
    int n_total;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (rdy32),
        .in_inst    (in_inst),
        .in_tag     (in_tag),
        .out_valid  (vld32),
        .out_ready  (out_ready),
        .out_imm    (imm32),
        .out_fmt    (fmt32),
        .out_illegal(ill32),
        .out_tag    (tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (rdy64),
        .in_inst    (in_inst),
        .in_tag     (in_tag),
        .out_valid  (vld64),
        .out_ready  (out_ready),
        .out_imm    (imm64),
        .out_fmt    (fmt64),
        .out_illegal(ill64),
        .out_tag    (tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] m32,
                                input logic [2:0] f32, input logic [63:0] m64,
                                input logic [2:0] f64);
        vec_t v;
        v.inst  = i;
        v.imm32 = m32;
        v.fmt32 = f32;
        v.imm64 = m64;
        v.fmt64 = f64;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic check_out(input string name, input vec_t v, input logic [31:0] tag);
        check({name, " valid32"}, 64'(vld32), 64'd1);
        check({name, " valid64"}, 64'(vld64), 64'd1);
        check({name, " imm32"}, 64'(imm32), 64'(v.imm32));
        check({name, " fmt32"}, 64'(fmt32), 64'(v.fmt32));
        check({name, " ill32"}, 64'(ill32), 64'(v.fmt32 == 3'd7));
        check({name, " tag32"}, 64'(tag32), 64'(tag));
        check({name, " imm64"}, imm64, v.imm64);
        check({name, " fmt64"}, 64'(fmt64), 64'(v.fmt64));
        check({name, " ill64"}, 64'(ill64), 64'(v.fmt64 == 3'd7));
        check({name, " tag64"}, 64'(tag64), 64'(tag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        va, vb, vc, vd, ve, vg;
        logic [31:0] got_tags[$];
        logic [31:0] got_imms[$];
        logic        acc;
        int          n;
        int          spurious;

        n_pass = 0;
        n_total = 0;

        vecs.push_back(mk(32'hFFF00093, 32'hFFFFFFFF, 3'd2, 64'hFFFFFFFFFFFFFFFF, 3'd2));
        vecs.push_back(mk(32'hFE000EE3, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5));
        vecs.push_back(mk(32'h0010006F, 32'h00000800, 3'd1, 64'h0000000000000800, 3'd1));
        vecs.push_back(mk(32'h01F09093, 32'h0000001F, 3'd3, 64'h000000000000001F, 3'd3));
        vecs.push_back(mk(32'hABCDE2B7, 32'hABCDE000, 3'd0, 64'hFFFFFFFFABCDE000, 3'd0));
        vecs.push_back(mk(32'h03F09093, 32'h00000000, 3'd7, 64'h000000000000003F, 3'd3));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 3'd7, 64'h0, 3'd7));
        vecs.push_back(mk(32'h0000007F, 32'h00000000, 3'd7, 64'h0, 3'd7));
        vecs.push_back(mk(32'hFE112E23, 32'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd4));
        vecs.push_back(mk(32'h00001517, 32'h00001000, 3'd0, 64'h0000000000001000, 3'd0));
        vecs.push_back(mk(32'h002081B3, 32'h00000000, 3'd6, 64'h0, 3'd6));
        vecs.push_back(mk(32'h002081BB, 32'h00000000, 3'd7, 64'h0, 3'd6));
        vecs.push_back(mk(32'h0010909B, 32'h00000000, 3'd7, 64'h1, 3'd3));
        vecs.push_back(mk(32'h0200909B, 32'h00000000, 3'd7, 64'h0, 3'd7));
        vecs.push_back(mk(32'hFFF0809B, 32'h00000000, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd2));
        vecs.push_back(mk(32'h80002083, 32'hFFFFF800, 3'd2, 64'hFFFFFFFFFFFFF800, 3'd2));
        vecs.push_back(mk(32'h000080E7, 32'h00000000, 3'd2, 64'h0, 3'd2));
        vecs.push_back(mk(32'h0FF0000F, 32'h00000000, 3'd6, 64'h0, 3'd6));
        vecs.push_back(mk(32'h40515093, 32'h00000005, 3'd3, 64'h5, 3'd3));
        vecs.push_back(mk(32'h00000073, 32'h00000000, 3'd6, 64'h0, 3'd6));
`ifdef IMMGEN_ZIMM_EN
        vecs.push_back(mk(32'h3400D073, 32'h00000001, 3'd3, 64'h1, 3'd3));
`else
        vecs.push_back(mk(32'h3400D073, 32'h00000000, 3'd6, 64'h0, 3'd6));
`endif
        vecs.push_back(mk(32'h00000001, 32'h00000000, 3'd7, 64'h0, 3'd7));

        // Reset held two cycles with an instruction offered: nothing may be captured.
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'hFFF00093;
        in_tag = 32'hDEAD;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset out_valid", 64'(vld32), 64'd0);
        check("reset in_ready", 64'(rdy32), 64'd1);
        check("reset imm32", 64'(imm32), 64'd0);
        check("reset fmt32", 64'(fmt32), 64'd6);
        check("reset ill32", 64'(ill32), 64'd0);
        check("reset tag32", 64'(tag32), 64'd0);
        check("reset imm64", imm64, 64'd0);
        check("reset fmt64", 64'(fmt64), 64'd6);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset out_valid", 64'(vld64), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back stream: vector k accepted at edge k, visible after edge k+1.
        n = vecs.size();
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                in_valid = 1'b1;
                in_inst = vecs[k].inst;
                in_tag = 32'h100 + 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < n) begin
                check($sformatf("v%0d in_ready32", k), 64'(rdy32), 64'd1);
                check($sformatf("v%0d in_ready64", k), 64'(rdy64), 64'd1);
            end
            if (k == 1) check("latency out_valid", 64'(vld32), 64'd0);
            if (k >= 2) check_out($sformatf("v%0d", k - 2), vecs[k - 2], 32'h100 + 32'(k - 2));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stream drained", 64'(vld32), 64'd0);
        @(posedge clk);
        #1;

        // Stall: three offered with out_ready low, only two fit.
        va = mk(32'hFE112E23, 32'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd4);
        vb = mk(32'h00001517, 32'h00001000, 3'd0, 64'h1000, 3'd0);
        vc = mk(32'h80002083, 32'hFFFFF800, 3'd2, 64'hFFFFFFFFFFFFF800, 3'd2);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = va.inst;
        in_tag = 32'hA0;
        @(negedge clk);
        check("stall A in_ready", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        in_inst = vb.inst;
        in_tag = 32'hB0;
        @(negedge clk);
        check("stall B in_ready", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        in_inst = vc.inst;
        in_tag = 32'hC0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d in_ready", c), 64'(rdy32), 64'd0);
            check_out($sformatf("stall%0d A", c), va, 32'hA0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (vld32) begin
                got_tags.push_back(tag32);
                got_imms.push_back(imm32);
            end
            acc = in_valid && rdy32;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        check("drain count", 64'(got_tags.size()), 64'd3);
        if (got_tags.size() == 3) begin
            check("drain tag0", 64'(got_tags[0]), 64'hA0);
            check("drain tag1", 64'(got_tags[1]), 64'hB0);
            check("drain tag2", 64'(got_tags[2]), 64'hC0);
            check("drain imm0", 64'(got_imms[0]), 64'(va.imm32));
            check("drain imm1", 64'(got_imms[1]), 64'(vb.imm32));
            check("drain imm2", 64'(got_imms[2]), 64'(vc.imm32));
        end

        // Flush with two entries in flight and a third offered.
        vd = mk(32'hFFF00093, 32'hFFFFFFFF, 3'd2, 64'hFFFFFFFFFFFFFFFF, 3'd2);
        ve = mk(32'h0010006F, 32'h00000800, 3'd1, 64'h800, 3'd1);
        vg = mk(32'h00112623, 32'h0000000C, 3'd4, 64'hC, 3'd4);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = vd.inst;
        in_tag = 32'hD0;
        @(posedge clk);
        #1;
        in_inst = ve.inst;
        in_tag = 32'hE0;
        @(posedge clk);
        #1;
        in_inst = 32'hABCDE2B7;
        in_tag = 32'hF0;
        flush = 1'b1;
        @(negedge clk);
        check("flush in_ready", 64'(rdy32), 64'd0);
        check_out("pre-flush D", vd, 32'hD0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post-flush out_valid", 64'(vld32), 64'd0);
        check("post-flush in_ready", 64'(rdy32), 64'd1);
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (vld32 || vld64) spurious++;
        end
        check("flushed never emitted", 64'(spurious), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_inst = vg.inst;
        in_tag = 32'h60;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("recover latency", 64'(vld32), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out("recover G", vg, 32'h60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-register immediate generator. Takes whole 32-bit RV instructions over a valid/ready handshake and decodes the immediate format from the opcode itself; no immsrc input. Emits an XLEN-wide immediate, a format code and an illegal flag after a 2-stage pipeline with full backpressure and flush. Sits between fetch/decode and the ALU operand mux; a sideband tag (PC/ROB id) travels alongside.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, sideband width, carried unmodified.

Ports:
clk  in  1  clock; all state on posedge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous kill of all in-flight entries.
in_valid  in  1  instruction offered.
in_ready  out  1  block can accept this cycle.
in_inst  in  32  raw instruction.
in_tag  in  TAG_W  sideband.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts.
out_imm  out  XLEN  sign-/zero-extended immediate.
out_fmt  out  3  0 U, 1 J, 2 I, 3 UIMM, 4 S, 5 B, 6 NONE, 7 ILLEGAL.
out_illegal  out  1  equals (out_fmt==7).
out_tag  out  TAG_W  sideband of this result.

Behaviour:
- Reset (rst=1 at posedge): both stage valid bits 0; out_imm 0, out_fmt 6, out_illegal 0, out_tag 0. rst dominates flush and in_valid.
- S1 registers in_inst/in_tag. S2 registers imm/fmt/illegal decoded combinationally from S1, plus tag. Outputs come straight from S2 registers.
- Advance rules: s2_adv = !s2_valid | out_ready; s1_adv = s1_valid & s2_adv; in_ready = (!s1_valid | s2_adv) & !flush. The out_ready→in_ready combinational path is intended.
- Latency: an instruction accepted at edge k drives out_valid=1 after edge k+1. Throughput is 1/cycle.
- Stall: out_valid=1 & out_ready=0 → out_* held bit-stable. S1 holds. At most 2 entries are in flight.
- flush=1 at an edge: both valid bits cleared. in_valid is ignored that cycle. Data registers may keep stale values.
- Decode on S1 instruction. If inst[1:0]!=2'b11 → ILLEGAL.
- 0110111 LUI and 0010111 AUIPC → U: sext({i[31:12],12'b0}).
- 1101111 → J: sext({i[31],i[19:12],i[20],i[30:21],0}).
- 1100111 JALR and 0000011 LOAD → I: sext(i[31:20]).
- 0100011 → S: sext({i[31:25],i[11:7]}).
- 1100011 → B: sext({i[31],i[7],i[30:25],i[11:8],0}).
- 0010011 OP-IMM: funct3 001/101 → UIMM, zext shamt. Shamt is i[24:20] for XLEN=32 and i[25:20] for XLEN=64. XLEN=32 with i[25]=1 → ILLEGAL. Other funct3 values → I.
- 0011011 OP-IMM-32: XLEN=64 only, same rules with 5-bit shamt; i[25]=1 → ILLEGAL. XLEN=32 → ILLEGAL.
- 0110011 OP and 0001111 FENCE → NONE, imm 0. 0111011 OP-32 → NONE if XLEN=64, else ILLEGAL.
- 1110011 SYSTEM → NONE, imm 0 (see optional feature).
- Any other opcode → ILLEGAL, imm 0.
- Sign extension always replicates instruction bit 31 up to XLEN-1.

Optional Feature:
IMMGEN_ZIMM_EN. Defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → UIMM, out_imm = zext(i[19:15]); other SYSTEM stays NONE. Undefined: all SYSTEM → NONE, imm 0. No port change.

Test Plan:
- Hold rst 2 cycles then release with in_valid=0 → out_valid 0, in_ready 1, out_imm 0, out_fmt 6.
- XLEN=32: stream 0xFFF00093, 0xFE000EE3, 0x0010006F, 0x01F09093 back-to-back with out_ready=1 → outputs in order: 0xFFFFFFFF/2, 0xFFFFFFFC/5, 0x00000800/1, 0x0000001F/3. The first appears after acceptance edge +1, then one per cycle, tags in order.
- XLEN=64: 0xABCDE2B7 → 0xFFFFFFFFABCDE000, fmt 0. 0x03F09093 → 0x3F, fmt 3. Same instruction at XLEN=32 → fmt 7, illegal 1, imm 0.
- 0x00000000 and 0x0000007F → fmt 7, out_illegal 1, out_imm 0.
- out_ready=0 while offering 3 instructions → 2 accepted, then in_ready 0, out_* stable. Raise out_ready → remaining results drain in order with no loss or duplication.
- flush asserted with 2 entries in flight and in_valid=1 → in_ready 0, out_valid 0 next cycle, nothing from the flushed entries ever emitted.
- With IMMGEN_ZIMM_EN: 0x3400D073 (csrrwi, uimm 1) → imm 1, fmt 3. Without the macro → imm 0, fmt 6.
